// File: rtl/trap_return_stack_pkg.sv
// Shared types and defaults for the trap return stack (package trap_pkg).
// The saved context is {pc, mode}; MODE_ADMIN is the mode restored by reset.
package trap_pkg;

  localparam int TRAP_DEPTH = 4;
  localparam int TRAP_PC_W  = 16;

  localparam logic [1:0] MODE_ADMIN = 2'b11;

  typedef struct packed {
    logic [TRAP_PC_W-1:0] pc;
    logic [1:0]           mode;
  } trap_ctx_t;

endpackage

// File: rtl/trap_lifo.sv
// LIFO of saved trap contexts: storage array plus occupancy pointer.
// The top entry is read combinationally so a pop can be registered downstream.
module trap_lifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic [AW-1:0] w_wrIdx;
  logic [AW-1:0] w_rdIdx;
  logic          w_doPush;
  logic          w_doPop;

  // When full the low pointer bits wrap to 0, so the read index lands on DEPTH-1.
  assign w_wrIdx  = r_count[AW-1:0];
  assign w_rdIdx  = w_wrIdx - IDX_ONE;
  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[w_rdIdx];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty & ~i_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + CNT_ONE;
    end else if (w_doPop) begin
      r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= i_data;
    end
  end

endmodule

// File: rtl/trap_return_stack.sv
// Trap return unit: saves {PC, mode} on trap entry, replays it on return-from-trap.
// Define TRAP_NEST_EN for a DEPTH-entry LIFO; otherwise a single context register.
import trap_pkg::*;

module trap_return_stack #(
  parameter int DEPTH = TRAP_DEPTH,
  parameter int PC_W  = TRAP_PC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Store_Current,
  input  logic [PC_W-1:0]        cur_PC,
  input  logic [1:0]             cur_Mode,
  input  logic                   rti,
  input  logic                   IFID_Stall,
  input  logic                   miss,
  output logic                   ret_J,
  output logic [PC_W-1:0]        ret_PC,
  output logic [1:0]             ret_Mode,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int CW = PC_W + 2;

  logic            w_pushOk;
  logic            w_popOk;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_top;
  logic [DW-1:0]   w_depth;
  logic            r_retJ;
  logic [PC_W-1:0] r_retPC;
  logic [1:0]      r_retMode;
  logic            r_overflow;
  logic            r_underflow;

  // A trap entry preempts a coincident rti, so push and pop never both succeed.
  assign w_pushOk = Store_Current & ~miss;
  assign w_popOk  = rti & ~miss & ~IFID_Stall & ~Store_Current;

`ifdef TRAP_NEST_EN
  trap_lifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_pushOk),
    .i_pop   (w_popOk),
    .i_data  ({cur_PC, cur_Mode}),
    .o_data  (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_depth)
  );
`else
  logic          r_valid;
  logic [CW-1:0] r_ctx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctx   <= '0;
    end else if (w_pushOk && !r_valid) begin
      r_valid <= 1'b1;
      r_ctx   <= {cur_PC, cur_Mode};
    end else if (w_popOk && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign w_full  = r_valid;
  assign w_empty = ~r_valid;
  assign w_top   = r_ctx;
  assign w_depth = {{(DW-1){1'b0}}, r_valid};
`endif

  // Redirect outputs hold their last target; only ret_J and underflow are pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retJ      <= 1'b0;
      r_retPC     <= '0;
      r_retMode   <= MODE_ADMIN;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_retJ      <= w_popOk & ~w_empty;
      r_underflow <= w_popOk & w_empty;
      if (w_pushOk && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_popOk && !w_empty) begin
        {r_retPC, r_retMode} <= w_top;
      end
    end
  end

  assign ret_J     = r_retJ;
  assign ret_PC    = r_retPC;
  assign ret_Mode  = r_retMode;
  assign depth     = w_depth;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_trap_return_stack.sv
// Directed bench for trap_return_stack; expectations follow TRAP_NEST_EN.
// Inputs change 1 time unit after each rising edge, outputs are sampled there too.
module tb_trap_return_stack;
  import trap_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 16;
`ifdef TRAP_NEST_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            Store_Current = 1'b0;
  logic [PC_W-1:0] cur_PC = '0;
  logic [1:0]      cur_Mode = '0;
  logic            rti = 1'b0;
  logic            IFID_Stall = 1'b0;
  logic            miss = 1'b0;
  logic            ret_J;
  logic [PC_W-1:0] ret_PC;
  logic [1:0]      ret_Mode;
  logic [$clog2(DEPTH):0] depth;
  logic            overflow;
  logic            underflow;

  int nCompared   = 0;
  int nMismatched = 0;

  trap_return_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .Store_Current (Store_Current),
    .cur_PC        (cur_PC),
    .cur_Mode      (cur_Mode),
    .rti           (rti),
    .IFID_Stall    (IFID_Stall),
    .miss          (miss),
    .ret_J         (ret_J),
    .ret_PC        (ret_PC),
    .ret_Mode      (ret_Mode),
    .depth         (depth),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic sc, input logic [PC_W-1:0] pc, input logic [1:0] md,
                     input logic r, input logic st, input logic ms);
    Store_Current = sc; cur_PC = pc; cur_Mode = md; rti = r; IFID_Stall = st; miss = ms;
    tick();
    Store_Current = 1'b0; rti = 1'b0; IFID_Stall = 1'b0; miss = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 16'h0000, 2'b00, 0, 0, 0);
    nCompared++; if (depth !== 0) begin nMismatched++; $display("[TB] FAIL reset_depth: got %0d want 0", depth); end
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_retJ: got %b want 0", ret_J); end
    nCompared++; if (ret_PC !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_retPC: got %h want 0000", ret_PC); end
    nCompared++; if (ret_Mode !== 2'b11) begin nMismatched++; $display("[TB] FAIL reset_retMode: got %b want 11", ret_Mode); end
    nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    nCompared++; if (underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 16'h1234, 2'b00, 0, 0, 0);
    nCompared++; if (depth !== 1) begin nMismatched++; $display("[TB] FAIL single_push_depth: got %0d want 1", depth); end
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_push_retJ: got %b want 0", ret_J); end
    cyc(0, 16'h0000, 2'b00, 0, 0, 0);
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_pop_retJ: got %b want 1", ret_J); end
    nCompared++; if (ret_PC !== 16'h1234) begin nMismatched++; $display("[TB] FAIL single_pop_retPC: got %h want 1234", ret_PC); end
    nCompared++; if (ret_Mode !== 2'b00) begin nMismatched++; $display("[TB] FAIL single_pop_retMode: got %b want 00", ret_Mode); end
    nCompared++; if (depth !== 0) begin nMismatched++; $display("[TB] FAIL single_pop_depth: got %0d want 0", depth); end
    cyc(0, 16'h0000, 2'b00, 0, 0, 0);
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_pulse_retJ: got %b want 0", ret_J); end
    nCompared++; if (ret_PC !== 16'h1234) begin nMismatched++; $display("[TB] FAIL single_hold_retPC: got %h want 1234", ret_PC); end
  endtask

  task automatic test_nested();
    trap_ctx_t ent [3];
    int stored;
    ent[0] = '{pc: 16'h0040, mode: 2'b01};
    ent[1] = '{pc: 16'h0090, mode: 2'b11};
    ent[2] = '{pc: 16'h0300, mode: 2'b00};
    do_reset();
    stored = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, ent[i].pc, ent[i].mode, 0, 0, 0);
      if (stored < CAP) stored++;
      nCompared++; if (depth !== stored) begin nMismatched++; $display("[TB] FAIL nested_push%0d_depth: got %0d want %0d", i, depth, stored); end
      nCompared++; if (overflow !== ((i + 1) > CAP)) begin nMismatched++; $display("[TB] FAIL nested_push%0d_overflow: got %b want %b", i, overflow, ((i + 1) > CAP)); end
    end
    for (int k = stored - 1; k >= 0; k--) begin
      cyc(0, 16'h0000, 2'b00, 1, 0, 0);
      nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL nested_pop%0d_retJ: got %b want 1", k, ret_J); end
      nCompared++; if (ret_PC !== ent[k].pc) begin nMismatched++; $display("[TB] FAIL nested_pop%0d_retPC: got %h want %h", k, ret_PC, ent[k].pc); end
      nCompared++; if (ret_Mode !== ent[k].mode) begin nMismatched++; $display("[TB] FAIL nested_pop%0d_retMode: got %b want %b", k, ret_Mode, ent[k].mode); end
    end
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL nested_empty_retJ: got %b want 0", ret_J); end
    nCompared++; if (underflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL nested_empty_underflow: got %b want 1", underflow); end
    cyc(0, 16'h0000, 2'b00, 0, 0, 0);
    nCompared++; if (underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL nested_underflow_pulse: got %b want 0", underflow); end
  endtask

  task automatic test_overflow();
    logic [PC_W-1:0] pc;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      pc = 16'h1000 + 16'(i);
      cyc(1, pc, 2'(i), 0, 0, 0);
    end
    nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
    nCompared++; if (depth !== CAP) begin nMismatched++; $display("[TB] FAIL ovf_depth: got %0d want %0d", depth, CAP); end
    for (int k = CAP; k >= 1; k--) begin
      pc = 16'h1000 + 16'(k);
      cyc(0, 16'h0000, 2'b00, 1, 0, 0);
      nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_pop%0d_retJ: got %b want 1", k, ret_J); end
      nCompared++; if (ret_PC !== pc) begin nMismatched++; $display("[TB] FAIL ovf_pop%0d_retPC: got %h want %h", k, ret_PC, pc); end
      nCompared++; if (ret_Mode !== 2'(k)) begin nMismatched++; $display("[TB] FAIL ovf_pop%0d_retMode: got %b want %b", k, ret_Mode, 2'(k)); end
    end
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (underflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_underflow: got %b want 1", underflow); end
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_extra_retJ: got %b want 0", ret_J); end
    nCompared++; if (ret_PC !== 16'h1001) begin nMismatched++; $display("[TB] FAIL ovf_hold_retPC: got %h want 1001", ret_PC); end
    nCompared++; if (overflow !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_mixed();
    do_reset();
    cyc(1, 16'h0555, 2'b01, 1, 0, 0);
    nCompared++; if (depth !== 1) begin nMismatched++; $display("[TB] FAIL mixed_trap_rti_depth: got %0d want 1", depth); end
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL mixed_trap_rti_retJ: got %b want 0", ret_J); end
    nCompared++; if (underflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL mixed_trap_rti_underflow: got %b want 0", underflow); end
    cyc(0, 16'h0000, 2'b00, 1, 1, 0);
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL mixed_stall_retJ: got %b want 0", ret_J); end
    nCompared++; if (depth !== 1) begin nMismatched++; $display("[TB] FAIL mixed_stall_depth: got %0d want 1", depth); end
    cyc(0, 16'h0000, 2'b00, 1, 0, 1);
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL mixed_miss_rti_retJ: got %b want 0", ret_J); end
    nCompared++; if (depth !== 1) begin nMismatched++; $display("[TB] FAIL mixed_miss_rti_depth: got %0d want 1", depth); end
    cyc(1, 16'h0ABC, 2'b10, 0, 0, 1);
    nCompared++; if (depth !== 1) begin nMismatched++; $display("[TB] FAIL mixed_miss_push_depth: got %0d want 1", depth); end
    nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL mixed_miss_push_overflow: got %b want 0", overflow); end
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL mixed_pop_retJ: got %b want 1", ret_J); end
    nCompared++; if (ret_PC !== 16'h0555) begin nMismatched++; $display("[TB] FAIL mixed_pop_retPC: got %h want 0555", ret_PC); end
    nCompared++; if (ret_Mode !== 2'b01) begin nMismatched++; $display("[TB] FAIL mixed_pop_retMode: got %b want 01", ret_Mode); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 16'h2222, 2'b10, 0, 0, 0);
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_PC !== 16'h2222) begin nMismatched++; $display("[TB] FAIL b2b_first_retPC: got %h want 2222", ret_PC); end
    cyc(1, 16'h3333, 2'b01, 0, 0, 0);
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_push_retJ: got %b want 0", ret_J); end
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_second_retJ: got %b want 1", ret_J); end
    nCompared++; if (ret_PC !== 16'h3333) begin nMismatched++; $display("[TB] FAIL b2b_second_retPC: got %h want 3333", ret_PC); end
    nCompared++; if (ret_Mode !== 2'b01) begin nMismatched++; $display("[TB] FAIL b2b_second_retMode: got %b want 01", ret_Mode); end
  endtask

  task automatic test_reset_after_pop();
    do_reset();
    cyc(1, 16'h0777, 2'b10, 0, 0, 0);
    cyc(0, 16'h0000, 2'b00, 1, 0, 0);
    nCompared++; if (ret_J !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstpop_retJ_before: got %b want 1", ret_J); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nCompared++; if (ret_J !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstpop_retJ: got %b want 0", ret_J); end
    nCompared++; if (depth !== 0) begin nMismatched++; $display("[TB] FAIL rstpop_depth: got %0d want 0", depth); end
    nCompared++; if (ret_Mode !== 2'b11) begin nMismatched++; $display("[TB] FAIL rstpop_retMode: got %b want 11", ret_Mode); end
    nCompared++; if (ret_PC !== 16'h0000) begin nMismatched++; $display("[TB] FAIL rstpop_retPC: got %h want 0000", ret_PC); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nested();
    test_overflow();
    test_mixed();
    test_back_to_back();
    test_reset_after_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
